// File: rtl/rv_isa_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rv_isa_pkg : RV32I opcodes, class enum and funct3 names shared by the    |
// |              encoder and the main decoder.           Revision: 1.0       |
// +--------------------------------------------------------------------------+
package rv_isa_pkg;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  typedef enum logic [2:0] {
    CLS_R     = 3'd0,
    CLS_I_ALU = 3'd1,
    CLS_LOAD  = 3'd2,
    CLS_STORE = 3'd3,
    CLS_JALR  = 3'd4
  } cls_e;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;

  function automatic logic cls_legal(input logic [2:0] cls);
    return cls <= CLS_JALR;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sync_fifo : single-clock FIFO, power-of-two depth, storage cleared on    |
// |             reset so the head reads zero when empty. Revision: 1.0       |
// +--------------------------------------------------------------------------+
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/rv_instr_encoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rv_instr_encoder : packs field-level RV32I requests into 32-bit words    |
// |                    and queues them for the loader.   Revision: 1.0       |
// +--------------------------------------------------------------------------+
module rv_instr_encoder
  import rv_isa_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_cls,
  input  logic [2:0]       req_funct3,
  input  logic             req_f7b5,
  input  logic [4:0]       req_rd,
  input  logic [4:0]       req_rs1,
  input  logic [4:0]       req_rs2,
  input  logic [11:0]      req_imm,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [31:0]      instr,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic             f7b5_eff;
  logic [11:0]      imm_eff;
  logic [31:0]      word;
  logic             req_fire, legal, push, pop;
  logic             fifo_full, fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic             err_q, err_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  always_comb begin
    f7b5_eff = req_f7b5 && (req_funct3 == F3_ADD_SUB || req_funct3 == F3_SRL_SRA);
    imm_eff  = req_imm;
    // Shift-immediates carry only shamt plus the arithmetic-select bit.
    if (req_funct3 == F3_SLL || req_funct3 == F3_SRL_SRA)
      imm_eff = {1'b0, f7b5_eff, 5'b0, req_imm[4:0]};
    case (req_cls)
      CLS_R:     word = {1'b0, f7b5_eff, 5'b0, req_rs2, req_rs1, req_funct3, req_rd, OP_R};
      CLS_I_ALU: word = {imm_eff, req_rs1, req_funct3, req_rd, OP_IMM};
      CLS_LOAD:  word = {req_imm, req_rs1, req_funct3, req_rd, OP_LOAD};
      CLS_STORE: word = {req_imm[11:5], req_rs2, req_rs1, req_funct3, req_imm[4:0], OP_STORE};
      CLS_JALR:  word = {req_imm, req_rs1, 3'b000, req_rd, OP_JALR};
      default:   word = '0;
    endcase
  end

  assign req_ready   = (fifo_count != CW'(DEPTH));
  assign instr_valid = !fifo_empty;
  assign req_fire    = req_valid && req_ready;
  assign legal       = cls_legal(req_cls);
  assign push        = req_fire && legal && !fifo_full;
  assign pop         = instr_valid && instr_ready;

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (word),
    .pop   (pop),
    .dout  (instr),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    err_d     = req_fire && !legal;
    err_cnt_d = err_cnt_q;
    if (err_d && (err_cnt_q != '1))
      err_cnt_d = err_cnt_q + ERR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err     = err_q;
  assign err_cnt = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_rv_instr_encoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_rv_instr_encoder : directed vectors with hand-computed RV32I words.   |
// |                                                      Revision: 1.0       |
// +--------------------------------------------------------------------------+
module tb_rv_instr_encoder;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned ERR_W = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [2:0]       req_cls = '0;
  logic [2:0]       req_funct3 = '0;
  logic             req_f7b5 = 1'b0;
  logic [4:0]       req_rd = '0, req_rs1 = '0, req_rs2 = '0;
  logic [11:0]      req_imm = '0;
  logic             instr_valid;
  logic             instr_ready = 1'b0;
  logic [31:0]      instr;
  logic             err;
  logic [ERR_W-1:0] err_cnt;

  int n_chk = 0;
  int n_err = 0;

  rv_instr_encoder #(.DEPTH(DEPTH), .ERR_W(ERR_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_cls     (req_cls),
    .req_funct3  (req_funct3),
    .req_f7b5    (req_f7b5),
    .req_rd      (req_rd),
    .req_rs1     (req_rs1),
    .req_rs2     (req_rs2),
    .req_imm     (req_imm),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .err         (err),
    .err_cnt     (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] cls, input logic [2:0] f3, input logic f7,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [11:0] imm);
    req_cls = cls; req_funct3 = f3; req_f7b5 = f7;
    req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_imm = imm;
    req_valid = 1'b1;
  endtask

  // cls, funct3, f7b5, rd, rs1, rs2, imm, expected word
  logic [2:0]  m_cls [6] = '{3'd3, 3'd2, 3'd1, 3'd4, 3'd1, 3'd0};
  logic [2:0]  m_f3  [6] = '{3'b010, 3'b010, 3'b000, 3'b111, 3'b101, 3'b111};
  logic        m_f7  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  logic [4:0]  m_rd  [6] = '{5'd0, 5'd4, 5'd5, 5'd1, 5'd2, 5'd3};
  logic [4:0]  m_rs1 [6] = '{5'd1, 5'd2, 5'd0, 5'd5, 5'd1, 5'd1};
  logic [4:0]  m_rs2 [6] = '{5'd2, 5'd7, 5'd9, 5'd3, 5'd4, 5'd2};
  logic [11:0] m_imm [6] = '{12'd8, 12'd4, 12'hFFF, 12'd0, 12'hFE3, 12'd0};
  logic [31:0] m_exp [6] = '{32'h0020A423, 32'h00412203, 32'hFFF00293,
                             32'h000280E7, 32'h4030D113, 32'h0020F1B3};

  logic [31:0] bp_exp [5];
  int          n_out;
  logic        acc;

  initial begin
    // Reset state
    tick(); tick();
    rst = 1'b0;
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_instr", instr, 32'h0);
    check("rst_ready", {31'b0, req_ready}, 32'd1);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_errcnt", {30'b0, err_cnt}, 32'd0);

    // R-type ADD / SUB pair, back to back
    instr_ready = 1'b1;
    drive(3'd0, 3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 12'h0);
    tick();
    drive(3'd0, 3'b000, 1'b1, 5'd3, 5'd1, 5'd2, 12'h0);
    check("add_valid", {31'b0, instr_valid}, 32'd1);
    check("add_word", instr, 32'h002081B3);
    tick();
    req_valid = 1'b0;
    check("sub_valid", {31'b0, instr_valid}, 32'd1);
    check("sub_word", instr, 32'h402081B3);
    tick();
    check("pair_drained", {31'b0, instr_valid}, 32'd0);

    // Mixed classes streamed at one per cycle
    for (int i = 0; i < 6; i++) begin
      drive(m_cls[i], m_f3[i], m_f7[i], m_rd[i], m_rs1[i], m_rs2[i], m_imm[i]);
      tick();
      check($sformatf("mix%0d_word", i), instr, m_exp[i]);
    end
    req_valid = 1'b0;
    tick();
    check("mix_drained", {31'b0, instr_valid}, 32'd0);

    // Backpressure: 5 LOADs against a stalled consumer
    instr_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      bp_exp[i] = {12'(i + 16), 5'(i), 3'b010, 5'(i + 1), 7'b0000011};
    for (int i = 0; i < 4; i++) begin
      drive(3'd2, 3'b010, 1'b0, 5'(i + 1), 5'(i), 5'd0, 12'(i + 16));
      check($sformatf("bp_ready%0d", i), {31'b0, req_ready}, 32'd1);
      tick();
    end
    drive(3'd2, 3'b010, 1'b0, 5'd5, 5'd4, 5'd0, 12'd20);
    check("bp_full_ready", {31'b0, req_ready}, 32'd0);
    tick();
    check("bp_still_full", {31'b0, req_ready}, 32'd0);
    check("bp_head", instr, bp_exp[0]);
    instr_ready = 1'b1;
    n_out = 0;
    for (int c = 0; c < 12; c++) begin
      if (instr_valid) begin
        if (n_out < 5) check($sformatf("bp_out%0d", n_out), instr, bp_exp[n_out]);
        else check("bp_extra_word", instr, 32'hDEAD_BEEF);
        n_out++;
      end
      acc = req_valid && req_ready;
      tick();
      if (acc) req_valid = 1'b0;
    end
    check("bp_count", 32'(n_out), 32'd5);
    check("bp_drained", {31'b0, instr_valid}, 32'd0);

    // Illegal class: dropped, one-cycle err pulse, saturating counter
    drive(3'd6, 3'b000, 1'b0, 5'd1, 5'd1, 5'd1, 12'd1);
    check("ill_ready", {31'b0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
    check("ill_err", {31'b0, err}, 32'd1);
    check("ill_cnt1", {30'b0, err_cnt}, 32'd1);
    check("ill_novalid", {31'b0, instr_valid}, 32'd0);
    tick();
    check("ill_err_off", {31'b0, err}, 32'd0);
    check("ill_cnt_hold", {30'b0, err_cnt}, 32'd1);
    drive(3'd7, 3'b000, 1'b0, 5'd1, 5'd1, 5'd1, 12'd1);
    tick(); check("ill_cnt2", {30'b0, err_cnt}, 32'd2);
    req_cls = 3'd5;
    tick(); check("ill_cnt3", {30'b0, err_cnt}, 32'd3);
    tick(); check("ill_cnt_sat", {30'b0, err_cnt}, 32'd3);
    check("ill_err_stream", {31'b0, err}, 32'd1);
    req_valid = 1'b0;
    tick();
    check("ill_err_end", {31'b0, err}, 32'd0);
    check("ill_never_valid", {31'b0, instr_valid}, 32'd0);

    // Reset with three words queued
    instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(3'd1, 3'b000, 1'b0, 5'(i + 1), 5'd0, 5'd0, 12'(i + 1));
      tick();
    end
    req_valid = 1'b0;
    check("pre_rst_valid", {31'b0, instr_valid}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_valid", {31'b0, instr_valid}, 32'd0);
    check("mid_rst_instr", instr, 32'h0);
    check("mid_rst_ready", {31'b0, req_ready}, 32'd1);
    check("mid_rst_errcnt", {30'b0, err_cnt}, 32'd0);
    drive(3'd2, 3'b010, 1'b0, 5'd4, 5'd2, 5'd0, 12'd4);
    tick();
    req_valid = 1'b0;
    check("post_rst_valid", {31'b0, instr_valid}, 32'd1);
    check("post_rst_word", instr, 32'h00412203);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rv_instr_encoder.md
# rv_instr_encoder

Sequential RV32I instruction encoder for the control-unit test and program-load path: the encoding counterpart of the main decoder. It accepts field-level instruction requests over a valid/ready handshake. Each request is packed into a 32-bit RV32I word (R, I-ALU, LOAD, STORE, JALR classes, the set the main decoder handles) and buffered in a small FIFO. The words are then presented to the instruction memory loader or directly to the decoder bench over a second valid/ready handshake.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- ERR_W, 8, width of the saturating error counter
- clk  in  1  rising-edge clock, single domain
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  encoder can accept
- req_cls  in  3  class: 0=R, 1=I_ALU, 2=LOAD, 3=STORE, 4=JALR, 5–7 illegal
- req_funct3  in  3  funct3 field
- req_f7b5  in  1  instr[30] select (SUB/SRA/SRAI)
- req_rd, req_rs1, req_rs2  in  5 each  register indices
- req_imm  in  12  12-bit immediate
- instr_valid  out  1  encoded word available
- instr_ready  in  1  consumer takes word
- instr  out  32  encoded word at FIFO head
- err  out  1  one-cycle pulse: illegal class accepted and dropped
- err_cnt  out  ERR_W  saturating count of dropped requests

## Operation
- Handshake: a transfer occurs on a cycle where valid && ready. This holds for both ports. Producers hold payload stable while valid && !ready.
- req_ready = (count != DEPTH). It depends only on FIFO occupancy, not on instr_ready.
- instr_valid = (count != 0). instr always shows the head entry.
- Encoding, opcodes and bit fields:
  - R: {1'b0, f7b5_eff, 5'b0, rs2, rs1, funct3, rd, 7'b0110011}
  - I_ALU: {imm_eff, rs1, funct3, rd, 7'b0010011}
  - LOAD: {imm, rs1, funct3, rd, 7'b0000011}
  - STORE: {imm[11:5], rs2, rs1, funct3, imm[4:0], 7'b0100011}
  - JALR: {imm, rs1, 3'b000, rd, 7'b1100111}. funct3 is forced to 000 and req_funct3 is ignored.
- f7b5_eff = req_f7b5 only when funct3 ∈ {000, 101}; otherwise 0. For I_ALU, req_f7b5 is ignored when funct3=000 (ADDI).
- imm_eff for I_ALU:
  - funct3 ∈ {001, 101} (shifts): {1'b0, f7b5_eff, 5'b0, imm[4:0]}
  - otherwise: imm
- Fields a class does not use are ignored: rs2 for I/LOAD/JALR, rd for STORE.
- An illegal class (5–7) is still accepted (req_ready obeys the normal rule) but is not enqueued. In that case err pulses on the following cycle and err_cnt increments, saturating at 2^ERR_W−1.
- Simultaneous push and pop: allowed whenever req_ready=1. count is unchanged and the order is preserved.
- Pop while empty and push while full are impossible by construction. The pointers wrap modulo DEPTH.

## Timing
- Encoding is registered into the FIFO. An accepted legal request at edge N gives instr_valid=1 with the word after edge N (visible in cycle N+1) when the FIFO was empty. Latency is 1 cycle.
- Throughput is 1 word/cycle when instr_ready is held high.
- Full: once DEPTH words are held and instr_ready=0, req_ready drops in the next cycle. It rises again in the cycle after the first pop.
- Reset (synchronous, any time, including mid-burst) forces, at the next edge:
  - count=0, pointers=0, all storage=0
  - instr_valid=0, instr=32'h0, req_ready=1, err=0, err_cnt=0
  - Words in flight are discarded.
- No combinational path from req_* to instr_*. instr_ready affects only the next-state count.

## Structure
- Package rv_isa_pkg holds:
  - opcode constants OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_JALR
  - class enum cls_e
  - funct3 constants for ADD/SUB, SLL, SRL/SRA
  - The main decoder uses the same package.
- Sub-module sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/count) holds the storage. rv_instr_encoder contains the packing logic, handshake glue and error counter.

## Test plan
- R-type pair: R, funct3=000, rd=3, rs1=1, rs2=2, f7b5=0, then the same with f7b5=1, with instr_ready=1. Required: 0x002081B3 then 0x402081B3 on consecutive cycles, each 1 cycle after acceptance.
- Mixed classes:
  - STORE rs2=2, rs1=1, funct3=010, imm=8 → 0x0020A423
  - LOAD rd=4, rs1=2, funct3=010, imm=4 → 0x00412203
  - I_ALU rd=5, rs1=0, funct3=000, imm=0xFFF → 0xFFF00293
  - JALR rd=1, rs1=5, funct3=111, imm=0 → 0x000280E7 (funct3 forced)
- Backpressure: instr_ready=0, push 5 legal requests. Required: req_ready=0 after 4 accepts. Release instr_ready and check all 5 words drain in order with no loss or duplication.
- Illegal class: req_cls=6 accepted. Required: no instr_valid, err=1 for exactly one cycle, err_cnt=1. With ERR_W=2, 4 illegals hold err_cnt at 3.
- Reset mid-operation: 3 words queued, assert rst for one cycle. Required: instr_valid=0, instr=0, req_ready=1, err_cnt=0 next cycle. A subsequent request encodes correctly with 1-cycle latency.
